// File: rtl/hsb_axis_pkg.sv
// hsb_axis_pkg: shared types and byte-lane helpers for the AXIS packet limiter
package hsb_axis_pkg;
  localparam int C_KEEP_MAX = 64;
  typedef logic [15:0] len_t;
  typedef enum logic {PASS, DISCARD} state_t;
  function automatic int c_bytes(input int width);
    return width / 8;
  endfunction
  function automatic len_t popcount(input logic [C_KEEP_MAX-1:0] k);
    len_t n = '0;
    for (int i = 0; i < C_KEEP_MAX; i++) n += len_t'(k[i]);
    return n;
  endfunction
  function automatic logic [C_KEEP_MAX-1:0] keep_mask(input int n);
    return n >= C_KEEP_MAX ? '1 : (64'(1) << n) - 64'(1);
  endfunction
endpackage

// File: rtl/hsb_axis_skid_buf.sv
// hsb_axis_skid_buf: 2-entry registered skid buffer, s_ready driven only from registers
module hsb_axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  logic [W-1:0] skid_data;
  logic skid_valid, load_main, in_fire, skid_nxt, m_valid_nxt;
  always_comb begin
    in_fire = s_valid && s_ready;
    load_main = !m_valid || m_ready;
    skid_nxt = load_main ? 1'b0 : (skid_valid || in_fire);
    m_valid_nxt = load_main ? (skid_valid || in_fire) : 1'b1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      skid_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      m_valid <= m_valid_nxt;
      skid_valid <= skid_nxt;
      s_ready <= !skid_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (load_main) m_data <= skid_valid ? skid_data : s_data;
    if (!load_main && in_fire) skid_data <= s_data;
  end
endmodule

// File: rtl/hsb_axis_pkt_limiter.sv
// hsb_axis_pkt_limiter: caps AXIS packets at C_MAX_BYTES, trimming the crossing beat and
// dropping the remainder, and reports each forwarded packet's length.
module hsb_axis_pkt_limiter
  import hsb_axis_pkg::*;
#(
  parameter int C_TDATA_WIDTH = 96,
  parameter int C_TUSER_WIDTH = 1,
  parameter int C_MAX_BYTES = 1488
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [C_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       pkt_len_valid,
  output logic [15:0]                pkt_len_bytes,
  output logic                       pkt_truncated
);
  localparam int C_BYTES = c_bytes(C_TDATA_WIDTH);
  localparam int PW = C_TDATA_WIDTH + C_BYTES + C_TUSER_WIDTH + 1 + 16 + 1;
  state_t state;
  len_t running, n_bytes, room, len_o, m_len;
  logic [16:0] sum;
  logic [C_BYTES-1:0] mask, keep_o;
  logic [C_TDATA_WIDTH-1:0] data_o;
  logic [PW-1:0] m_payload;
  logic over, at_max, out_last, trunc_o, push, skid_ready, m_trunc;
  always_comb begin
    n_bytes = popcount(64'(s_axis_tkeep));
    sum = {1'b0, running} + {1'b0, n_bytes};
    over = sum > 17'(C_MAX_BYTES);
    at_max = sum == 17'(C_MAX_BYTES);
    room = len_t'(C_MAX_BYTES) - running;
    mask = C_BYTES'(keep_mask(over ? int'(room) : C_BYTES));
    keep_o = s_axis_tkeep & mask;
    out_last = s_axis_tlast || over || at_max;
    trunc_o = over || (at_max && !s_axis_tlast);
    len_o = over ? len_t'(C_MAX_BYTES) : sum[15:0];
    push = state == PASS && s_axis_tvalid && skid_ready;
  end
  for (genvar i = 0; i < C_BYTES; i++) begin : g_trim
    assign data_o[8*i+:8] = mask[i] ? s_axis_tdata[8*i+:8] : 8'h00;
  end
  assign s_axis_tready = state == DISCARD || skid_ready;
  // The count follows the input side: the next packet may enter while this one's tail is still buffered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= PASS;
      running <= '0;
    end else if (state == DISCARD) begin
      if (s_axis_tvalid && s_axis_tlast) state <= PASS;
    end else if (push) begin
      running <= out_last ? '0 : sum[15:0];
      if (trunc_o && !s_axis_tlast) state <= DISCARD;
    end
  end
  hsb_axis_skid_buf #(.W(PW)) u_skid (
    .clk(clk),
    .resetn(resetn),
    .s_data({data_o, keep_o, s_axis_tuser, out_last, len_o, trunc_o}),
    .s_valid(push),
    .s_ready(skid_ready),
    .m_data(m_payload),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_len, m_trunc} = m_payload;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_len_valid <= 1'b0;
      pkt_len_bytes <= '0;
      pkt_truncated <= 1'b0;
    end else begin
      pkt_len_valid <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_len_bytes <= m_len;
        pkt_truncated <= m_trunc;
      end
    end
  end
endmodule

// File: tb/tb_hsb_axis_pkt_limiter.sv
// tb_hsb_axis_pkt_limiter: directed packets with 12-byte beats against a 48-byte cap
module tb_hsb_axis_pkt_limiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [95:0] s_axis_tdata = '0, m_axis_tdata;
  logic [11:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [0:0] s_axis_tuser = '0, m_axis_tuser;
  logic s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready = 1'b1;
  logic pkt_len_valid, pkt_truncated;
  logic [15:0] pkt_len_bytes;
  int total = 0, bad = 0;
  logic [109:0] exp_q[$];
  logic [16:0] len_q[$];
  logic [109:0] held_pl, pl;
  bit toggle = 0, hold = 0, held = 0;
  always #5 clk = ~clk;
  hsb_axis_pkt_limiter #(.C_TDATA_WIDTH(96), .C_TUSER_WIDTH(1), .C_MAX_BYTES(48)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_len_valid(pkt_len_valid), .pkt_len_bytes(pkt_len_bytes), .pkt_truncated(pkt_truncated)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [95:0] mk(input int p, input int i);
    logic [7:0] a, b;
    a = p[7:0];
    b = i[7:0];
    return {6{a, b}};
  endfunction
  // Output side: ready pattern, stall stability, beat and length scoreboards.
  always @(negedge clk) begin
    m_axis_tready = hold ? 1'b0 : toggle ? !m_axis_tready : 1'b1;
    pl = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    if (!resetn) held = 0;
    if (held) chk("stall_stable", {m_axis_tvalid, pl}, {1'b1, held_pl});
    held = m_axis_tvalid && !m_axis_tready;
    held_pl = pl;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else chk("beat", pl, exp_q.pop_front());
    end
    if (pkt_len_valid) begin
      if (len_q.size() == 0) chk("extra_len", 1, 0);
      else chk("len", {pkt_truncated, pkt_len_bytes}, len_q.pop_front());
    end
  end
  task automatic beat(input logic [95:0] d, input logic [11:0] k, input logic l, input logic u);
    int n = 0;
    @(negedge clk);
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
  endtask
  // n full beats of packet p; the first exp_n come out, the last of them with tlast.
  task automatic send(input int p, input int n, input int exp_n);
    for (int i = 0; i < n; i++) begin
      if (i < exp_n) exp_q.push_back({mk(p, i), 12'hFFF, i == exp_n - 1, i == 0});
      beat(mk(p, i), 12'hFFF, i == n - 1, i == 0);
    end
  endtask
  task automatic drain();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || len_q.size() != 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_beats", exp_q.size(), 0);
    chk("drain_len", len_q.size(), 0);
    toggle = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_len_valid", pkt_len_valid, 0);
    chk("rst_len", {pkt_truncated, pkt_len_bytes}, 0);
    resetn = 1'b1;
    #1 chk("s_ready_pre_edge", s_axis_tready, 0);
    @(posedge clk);
    #1 chk("s_ready_post_edge", s_axis_tready, 1);
    len_q.push_back({1'b0, 16'd36});
    send(1, 3, 3);
    drain();
    len_q.push_back({1'b0, 16'd48});
    send(2, 4, 4);
    drain();
    len_q.push_back({1'b1, 16'd48});
    send(3, 6, 4);
    drain();
    len_q.push_back({1'b0, 16'd44});
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({mk(4, i), 12'hFFF, 1'b0, i == 0});
      beat(mk(4, i), 12'hFFF, 1'b0, i == 0);
    end
    exp_q.push_back({mk(4, 3), 12'h0FF, 1'b1, 1'b0});
    beat(mk(4, 3), 12'h0FF, 1'b1, 1'b0);
    len_q.push_back({1'b1, 16'd48});
    send(5, 7, 4);
    #1 chk("no_bubble", s_axis_tready, 1);
    len_q.push_back({1'b0, 16'd24});
    send(6, 2, 2);
    drain();
    len_q.push_back({1'b1, 16'd48});
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({mk(7, i), 12'hFFF, 1'b0, i == 0});
      beat(mk(7, i), 12'hFFF, 1'b0, i == 0);
    end
    exp_q.push_back({mk(7, 3), 12'h0FF, 1'b0, 1'b0});
    beat(mk(7, 3), 12'h0FF, 1'b0, 1'b0);
    exp_q.push_back({mk(7, 4) & 96'h0000_0000_0000_0000_FFFF_FFFF, 12'h00F, 1'b1, 1'b0});
    beat(mk(7, 4), 12'hFFF, 1'b0, 1'b0);
    beat(mk(7, 5), 12'hFFF, 1'b1, 1'b0);
    drain();
    toggle = 1;
    len_q.push_back({1'b1, 16'd48});
    send(8, 5, 4);
    drain();
    hold = 1;
    beat(mk(9, 0), 12'hFFF, 1'b0, 1'b1);
    beat(mk(9, 1), 12'hFFF, 1'b0, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("pre_rst_valid", m_axis_tvalid, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_axis_tvalid, 0);
    chk("mid_rst_s_ready", s_axis_tready, 0);
    chk("mid_rst_len_valid", pkt_len_valid, 0);
    chk("mid_rst_len", {pkt_truncated, pkt_len_bytes}, 0);
    hold = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    len_q.push_back({1'b0, 16'd24});
    send(10, 2, 2);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
